// File: rtl/niosii_system_sysid_pkg.sv
// ---------------------------------------------------------------------------
// niosii_system_sysid_pkg
//   Shared definitions for the system-ID register bank: word offsets of every
//   register, CTRL bit positions, the CAPS word layout and a byte-lane merge
//   helper used by the byte-writable registers.
// ---------------------------------------------------------------------------
package niosii_system_sysid_pkg;

  // Word offsets within the slave's address window.
  localparam int unsigned ADDR_ID       = 0;
  localparam int unsigned ADDR_TSTAMP   = 1;
  localparam int unsigned ADDR_CAPS     = 2;
  localparam int unsigned ADDR_CTRL     = 3;
  localparam int unsigned ADDR_UP_LO    = 4;
  localparam int unsigned ADDR_UP_HI    = 5;
  localparam int unsigned ADDR_SCRATCH0 = 6;

  // CTRL register bits; both live in byte lane 0.
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  // CAPS word: {16'h0, scratch count, block version}.
  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  n_scratch;
    logic [7:0]  version;
  } caps_t;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/niosii_system_sysid_uptime.sv
// ---------------------------------------------------------------------------
// niosii_system_sysid_uptime
//   Free-running 64-bit uptime counter with a high-word shadow so software can
//   read the 64-bit value as a coherent lo/hi pair.
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         count enable (counter advances by one per clock while high)
//   clr        synchronous clear; wins over en
//   snap       copy the current high word into hi_shadow (issued with a low read)
//   count      current counter value
//   hi_shadow  high word captured by the most recent snap
// ---------------------------------------------------------------------------
module niosii_system_sysid_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [63:0] count,
  output logic [31:0] hi_shadow
);

  logic [63:0] count_q, count_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps synthesis from inferring a latch.
    count_d     = count_q;
    hi_shadow_d = hi_shadow_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 64'd1;  // wraps silently at 2^64-1
    end
    // The snapshot takes the pre-update value, so a low read issued together
    // with a clear still pairs with the old high word.
    if (snap) hi_shadow_d = count_q[63:32];
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      hi_shadow_q <= '0;
    end else begin
      count_q     <= count_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign count     = count_q;
  assign hi_shadow = hi_shadow_q;

endmodule

// File: rtl/niosii_system_sysid_regs.sv
// ---------------------------------------------------------------------------
// niosii_system_sysid_regs
//   System-ID / info register bank on an Avalon-MM slave. Fixed read latency
//   of one clock with a readdatavalid strobe; no waitrequest.
//   Map: 0 ID, 1 TSTAMP, 2 CAPS, 3 CTRL, 4 UP_LO, 5 UP_HI, 6.. SCRATCH.
//   N_SCRATCH must be 1..4 and 6+N_SCRATCH must fit in 2**ADDR_W words.
// Ports
//   clock, reset_n          clock and asynchronous active-low reset
//   address                 word address
//   read, write             single-cycle access requests
//   byteenable, writedata   write lanes and data
//   readdata, readdatavalid registered read data and its 1-cycle strobe
// ---------------------------------------------------------------------------
module niosii_system_sysid_regs
  import niosii_system_sysid_pkg::*;
#(
  parameter logic [31:0] SYSID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter logic [7:0]  VERSION   = 8'd2,
  parameter int unsigned N_SCRATCH = 2,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam caps_t CAPS_VAL = '{rsvd: 16'h0, n_scratch: 8'(N_SCRATCH), version: VERSION};

  logic        ctrl_en_q, ctrl_en_d;
  logic [31:0] scratch_q [N_SCRATCH];
  logic [31:0] scratch_d [N_SCRATCH];
  logic [31:0] readdata_q, readdata_d;
  logic        readdatavalid_q, readdatavalid_d;

  logic        clr;
  logic        snap;
  logic [63:0] count;
  logic [31:0] hi_shadow;
  logic [31:0] rd_word;

  niosii_system_sysid_uptime u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (ctrl_en_q),
    .clr       (clr),
    .snap      (snap),
    .count     (count),
    .hi_shadow (hi_shadow)
  );

  // Write side: CTRL and SCRATCH are the only writable words.
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    clr       = 1'b0;
    scratch_d = scratch_q;
    if (write && address == ADDR_W'(ADDR_CTRL) && byteenable[0]) begin
      ctrl_en_d = writedata[CTRL_EN_BIT];
      clr       = writedata[CTRL_CLR_BIT];  // a pulse, never stored
    end
    for (int i = 0; i < N_SCRATCH; i++) begin
      if (write && address == ADDR_W'(ADDR_SCRATCH0 + i)) begin
        scratch_d[i] = apply_be(scratch_q[i], writedata, byteenable);
      end
    end
  end

  // Read mux works from current state, so a same-cycle write is not visible.
  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_W'(ADDR_ID):     rd_word = SYSID;
      ADDR_W'(ADDR_TSTAMP): rd_word = TIMESTAMP;
      ADDR_W'(ADDR_CAPS):   rd_word = CAPS_VAL;
      ADDR_W'(ADDR_CTRL):   rd_word = {31'h0, ctrl_en_q};
      ADDR_W'(ADDR_UP_LO):  rd_word = count[31:0];
      ADDR_W'(ADDR_UP_HI):  rd_word = hi_shadow;
      default: begin
        for (int i = 0; i < N_SCRATCH; i++) begin
          if (address == ADDR_W'(ADDR_SCRATCH0 + i)) rd_word = scratch_q[i];
        end
      end
    endcase
  end

  always_comb begin
    snap            = read && address == ADDR_W'(ADDR_UP_LO);
    readdatavalid_d = read;
    readdata_d      = readdata_q;  // holds until the next read
    if (read) readdata_d = rd_word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_q       <= 1'b1;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      // NOTE: the scratch words are a handful of flops with a defined reset
      // value, so they are reset here; a real RAM array would not be.
      for (int i = 0; i < N_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      ctrl_en_q       <= ctrl_en_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      scratch_q       <= scratch_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

  // Only the low word of the counter is read directly; the high word reaches
  // software through hi_shadow.
  logic unused_ok;
  assign unused_ok = ^count[63:32];

endmodule

// File: tb/tb_niosii_system_sysid_regs.sv
// ---------------------------------------------------------------------------
// tb_niosii_system_sysid_regs
//   Directed bench for the system-ID register bank. Stimulus tasks push the
//   hand-computed expected read result into a queue; a monitor pops and
//   compares whenever readdatavalid is seen.
// ---------------------------------------------------------------------------
module tb_niosii_system_sysid_regs;

  localparam int K_EQ   = 0;  // readdata must equal the value
  localparam int K_LT   = 1;  // readdata must be below the value
  localparam int K_CAP  = 2;  // remember readdata for a later K_PREV
  localparam int K_PREV = 3;  // readdata must equal the remembered value

  logic        clock;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  int          kind_q [$];
  string       name_q [$];

  niosii_system_sysid_regs #(
    .SYSID     (32'h1234_5678),
    .TIMESTAMP (32'h6000_0000),
    .VERSION   (8'd2),
    .N_SCRATCH (2),
    .ADDR_W    (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: samples outputs on the falling edge, away from the active edge.
  logic [31:0] cap_val  = '0;
  logic [31:0] last_val = '0;
  bit          have_last = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        last_val  = '0;
        have_last = 1'b1;
      end else if (readdatavalid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_valid", readdata, 32'h0);
        end else begin
          logic [31:0] e;
          int          k;
          string       nm;
          e  = exp_q.pop_front();
          k  = kind_q.pop_front();
          nm = name_q.pop_front();
          case (k)
            K_EQ:   check(readdata == e, nm, readdata, e);
            K_LT:   check(readdata < e, nm, readdata, e);
            K_PREV: check(readdata == cap_val, nm, readdata, cap_val);
            default: cap_val = readdata;
          endcase
        end
        last_val  = readdata;
        have_last = 1'b1;
      end else if (have_last) begin
        check(readdata == last_val, "readdata_hold", readdata, last_val);
      end
    end
  end

  // Stimulus tasks: called right after a falling edge, return one cycle later.
  task automatic rd(input logic [3:0] a, input int k, input logic [31:0] v,
                    input string nm);
    address = a;
    read    = 1'b1;
    exp_q.push_back(v);
    kind_q.push_back(k);
    name_q.push_back(nm);
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] v, input string nm);
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    rd(a, K_EQ, v, nm);
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    writedata  = '0;
    idle(3);
    check(readdatavalid == 1'b0, "rst_valid", {31'h0, readdatavalid}, 32'h0);
    check(readdata == 32'h0, "rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    idle(1);

    // 1: constant words back-to-back, then reset values of the state words.
    rd(4'd0, K_EQ, 32'h1234_5678, "id");
    rd(4'd1, K_EQ, 32'h6000_0000, "tstamp");
    rd(4'd2, K_EQ, 32'h0000_0202, "caps");
    rd(4'd5, K_EQ, 32'h0000_0000, "uphi_before_snap");
    rd(4'd3, K_EQ, 32'h0000_0001, "ctrl_rst");
    rd(4'd6, K_EQ, 32'h0000_0000, "scr0_rst");

    // 2: coherent lo/hi across a low-word carry.
    force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
    rd(4'd4, K_EQ, 32'hFFFF_FFFF, "uplo_forced");
    release dut.u_uptime.count_q;
    idle(4);
    rd(4'd5, K_EQ, 32'h0000_0001, "uphi_coherent");

    // 3: stop, freeze, then clear and restart.
    wr(4'd3, 32'h0, 4'hF);
    rd(4'd3, K_EQ, 32'h0000_0000, "ctrl_off");
    idle(10);
    rd(4'd4, K_CAP, 32'h0, "uplo_stopped_a");
    rd(4'd4, K_PREV, 32'h0, "uplo_stopped_b");
    wr(4'd3, 32'h3, 4'hF);
    rd(4'd4, K_LT, 32'd5, "uplo_after_clr");
    rd(4'd3, K_EQ, 32'h0000_0001, "ctrl_clr_selfclear");
    rd(4'd5, K_EQ, 32'h0000_0000, "uphi_after_clr");
    wr(4'd3, 32'h0, 4'b1110);
    rd(4'd3, K_EQ, 32'h0000_0001, "ctrl_lane0_masked");

    // 4: byte lanes, unmapped words, read-only protection.
    wr(4'd6, 32'hAABB_CCDD, 4'hF);
    wr(4'd6, 32'h1122_3344, 4'b0101);
    rd(4'd6, K_EQ, 32'hAA22_CC44, "scr0_byteen");
    rd(4'd15, K_EQ, 32'h0, "unmapped15");
    wr(4'd8, 32'hFFFF_FFFF, 4'hF);
    rd(4'd8, K_EQ, 32'h0, "unmapped8");
    rd(4'd7, K_EQ, 32'h0, "scr1_untouched");
    wr(4'd0, 32'hDEAD_BEEF, 4'hF);
    rd(4'd0, K_EQ, 32'h1234_5678, "id_ro");

    // 5: same-cycle read and write returns the old value.
    rdwr(4'd7, 32'h5, 4'hF, 32'h0, "scr1_rw_same_cycle");
    rd(4'd7, K_EQ, 32'h0000_0005, "scr1_new");

    // 6: reset just after a read is sampled drops the pending strobe.
    address = 4'd3;
    read    = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    read    = 1'b0;
    @(negedge clock);
    check(readdatavalid == 1'b0, "rst_mid_valid", {31'h0, readdatavalid}, 32'h0);
    check(readdata == 32'h0, "rst_mid_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    idle(1);
    rd(4'd3, K_EQ, 32'h0000_0001, "ctrl_en_after_rst");
    rd(4'd6, K_EQ, 32'h0000_0000, "scr0_after_rst");

    idle(3);
    check(exp_q.size() == 0, "responses_outstanding", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
